// File: rtl/freq_meter.sv
// Gated edge counter: counts synchronised rising edges of sig_in over a window of
// GATE_CYCLES clk cycles and reports the count, saturating at 2^CNT_W-1.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start or continuous
// S_ARM   | clear edge/gate counters and saturation flag
// S_COUNT | gate window open, rising edges counted
// S_DONE  | result_valid high for this cycle; re-arm or go idle
module freq_meter #(
    parameter int GATE_CYCLES = 1000,
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig_in,
    input  logic             start,
    input  logic             continuous,
    output logic             busy,
    output logic [CNT_W-1:0] result,
    output logic             result_valid,
    output logic             overflow
);

    localparam int GATE_W = $clog2(GATE_CYCLES + 1);
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_COUNT, S_DONE} state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic [CNT_W-1:0]       edge_cnt_q, edge_cnt_d;
    logic                   sat_q, sat_d;
    logic [GATE_W-1:0]      gate_cnt_q, gate_cnt_d;
    logic [CNT_W-1:0]       result_q, result_d;
    logic                   overflow_q, overflow_d;
    logic                   result_valid_q, result_valid_d;

    logic             rise;
    logic [CNT_W-1:0] edge_nxt;
    logic             sat_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start || continuous) state_d = S_ARM;
            S_ARM:   state_d = S_COUNT;
            S_COUNT: if (gate_cnt_q == GATE_LAST) state_d = S_DONE;
            S_DONE:  state_d = (start || continuous) ? S_ARM : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != S_IDLE);
    end

    // Synchroniser plus one extra flop for rising-edge detection.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], sig_in};
        prev_d = sync_q[SYNC_STAGES-1];
        rise   = sync_q[SYNC_STAGES-1] & ~prev_q;
    end

    always_comb begin
        edge_nxt = edge_cnt_q;
        sat_nxt  = sat_q;
        if (rise) begin
            if (edge_cnt_q == CNT_MAX) begin
                sat_nxt = 1'b1;
            end else begin
                edge_nxt = edge_cnt_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        edge_cnt_d     = edge_cnt_q;
        sat_d          = sat_q;
        gate_cnt_d     = gate_cnt_q;
        result_d       = result_q;
        overflow_d     = overflow_q;
        result_valid_d = 1'b0;
        case (state_q)
            S_ARM: begin
                edge_cnt_d = '0;
                sat_d      = 1'b0;
                gate_cnt_d = '0;
            end
            S_COUNT: begin
                edge_cnt_d = edge_nxt;
                sat_d      = sat_nxt;
                gate_cnt_d = gate_cnt_q + GATE_W'(1);
                // The edge seen in the final window cycle is part of the result.
                if (gate_cnt_q == GATE_LAST) begin
                    result_d       = edge_nxt;
                    overflow_d     = sat_nxt;
                    result_valid_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q         <= '0;
            prev_q         <= 1'b0;
            edge_cnt_q     <= '0;
            sat_q          <= 1'b0;
            gate_cnt_q     <= '0;
            result_q       <= '0;
            overflow_q     <= 1'b0;
            result_valid_q <= 1'b0;
        end else begin
            sync_q         <= sync_d;
            prev_q         <= prev_d;
            edge_cnt_q     <= edge_cnt_d;
            sat_q          <= sat_d;
            gate_cnt_q     <= gate_cnt_d;
            result_q       <= result_d;
            overflow_q     <= overflow_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign result       = result_q;
    assign overflow     = overflow_q;
    assign result_valid = result_valid_q;

endmodule

// File: tb/tb_freq_meter.sv
// Self-checking bench for freq_meter: sig_in follows a known waveform, expected
// window results are queued at start and compared when result_valid fires.
module tb_freq_meter;

    localparam int G    = 100;
    localparam int W    = 4;
    localparam int S    = 2;
    localparam int CMAX = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         sig_in = 1'b0;
    logic         start = 1'b0;
    logic         continuous = 1'b0;
    logic         busy;
    logic [W-1:0] result;
    logic         result_valid;
    logic         overflow;

    freq_meter #(.GATE_CYCLES(G), .CNT_W(W), .SYNC_STAGES(S)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sig_in       (sig_in),
        .start        (start),
        .continuous   (continuous),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // sig_in waveform: 0 low, 1 high, 2 square wave, 3 step high at pulse_j
    int mode = 0;
    int per = 10;
    int ph = 0;
    int pulse_j = 0;

    typedef struct {
        int due;
        int res;
        int ovf;
    } exp_t;
    exp_t q[$];

    function automatic int sig_at(int j);
        case (mode)
            0: return 0;
            1: return 1;
            2: return (((j + ph) % per) < (per / 2)) ? 1 : 0;
            default: return (j >= pulse_j) ? 1 : 0;
        endcase
    endfunction

    // A rise visible at posedge j is counted iff start was sampled at k and k <= j <= k+G-1.
    function automatic int exp_cnt(int k);
        int n = 0;
        for (int j = k; j < k + G; j++) begin
            if (sig_at(j) == 1 && sig_at(j - 1) == 0) n++;
        end
        return n;
    endfunction

    task automatic chk(input string tag, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cyc %0d)", tag, got, want, cyc);
        end
    endtask

    task automatic push_win(input int k);
        int n;
        exp_t e;
        n = exp_cnt(k);
        e.due = k + G + 1;
        e.res = (n > CMAX) ? CMAX : n;
        e.ovf = (n > CMAX) ? 1 : 0;
        q.push_back(e);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        push_win(cyc + 1);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic set_sig(input int m, input int p, input int f);
        mode = m;
        per  = p;
        ph   = f;
        repeat (6) @(negedge clk);
    endtask

    task automatic wait_done(input int max_cyc);
        int n = 0;
        @(negedge clk);
        while (!result_valid && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        if (!result_valid) chk("done_timeout", int'(result_valid), 1);
    endtask

    task automatic run_window(input string tag);
        pulse_start();
        wait_done(G + 10);
        chk({tag, "_busy_in_done"}, int'(busy), 1);
        @(negedge clk);
        chk({tag, "_busy_after"}, int'(busy), 0);
    endtask

    initial forever begin
        @(negedge clk);
        sig_in = (sig_at(cyc + 1) != 0);
    end

    logic last_v = 1'b0;
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (last_v) chk("valid_width", int'(result_valid), 0);
        if (result_valid) begin
            if (q.size() == 0) begin
                chk("spurious_valid", int'(result_valid), 0);
            end else begin
                e = q.pop_front();
                chk("valid_cyc", cyc, e.due);
                chk("result", int'(result), e.res);
                chk("overflow", int'(overflow), e.ovf);
            end
        end else if (q.size() > 0 && cyc > q[0].due) begin
            chk("valid_missing", int'(result_valid), 1);
            void'(q.pop_front());
        end
        last_v = result_valid;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got cyc %0d want finish", cyc);
        $fatal(1, "bench timeout");
    end

    initial begin
        int k;
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_result", int'(result), 0);
        chk("rst_valid", int'(result_valid), 0);
        chk("rst_ovf", int'(overflow), 0);
        rst_n = 1'b1;
        @(negedge clk);

        set_sig(2, 10, int'($urandom_range(0, 9)));
        run_window("p10");
        repeat (20) @(negedge clk);
        chk("result_hold", int'(result), 10);

        set_sig(0, 10, 0);
        run_window("low");
        set_sig(1, 10, 0);
        run_window("high");

        set_sig(2, 4, int'($urandom_range(0, 3)));
        run_window("p4_sat");
        chk("sat_result", int'(result), CMAX);
        chk("sat_ovf", int'(overflow), 1);
        set_sig(2, 20, int'($urandom_range(0, 19)));
        run_window("p20");
        chk("p20_ovf_clear", int'(overflow), 0);

        // extra start pulses during COUNT must not disturb the window
        set_sig(2, 10, int'($urandom_range(0, 9)));
        pulse_start();
        repeat (20) @(negedge clk);
        start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        repeat (30) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(G + 10);
        @(negedge clk);
        chk("xstart_busy_after", int'(busy), 0);

        // reset mid-COUNT
        pulse_start();
        repeat (40) @(negedge clk);
        #2 rst_n = 1'b0;
        q.delete();
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_result", int'(result), 0);
        chk("midrst_valid", int'(result_valid), 0);
        chk("midrst_ovf", int'(overflow), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (G + 20) @(negedge clk);
        chk("postrst_busy", int'(busy), 0);

        // continuous mode, dropped partway through the third window
        set_sig(2, 20, int'($urandom_range(0, 19)));
        continuous = 1'b1;
        k = cyc + 1;
        push_win(k);
        push_win(k + G + 2);
        push_win(k + 2 * (G + 2));
        repeat (2 * (G + 2) + 50) @(negedge clk);
        continuous = 1'b0;
        wait_done(G + 10);
        @(negedge clk);
        chk("cont_busy_after", int'(busy), 0);
        repeat (G + 10) @(negedge clk);
        chk("cont_queue_drained", q.size(), 0);
        chk("cont_busy_idle", int'(busy), 0);

        // single rise landing in ARM, first COUNT, last COUNT, just after window
        for (int t = 0; t < 4; t++) begin
            set_sig(0, 10, 0);
            k = cyc + 10;
            case (t)
                0: pulse_j = k - 1;
                1: pulse_j = k;
                2: pulse_j = k + G - 1;
                default: pulse_j = k + G;
            endcase
            mode = 3;
            repeat (9) @(negedge clk);
            pulse_start();
            wait_done(G + 10);
            chk("single_rise", int'(result), (t == 1 || t == 2) ? 1 : 0);
            repeat (5) @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
